// File: rtl/template_corr_scorer.sv
// Template correlation scorer: raster-scans a TPL_W x TPL_H window against a template,
// accumulating per-pixel similarity or SAD, with optional SAD early abort.
module template_corr_scorer #(
  parameter int PIX_W   = 10,
  parameter int TPL_W   = 32,
  parameter int TPL_H   = 32,
  parameter int COORD_W = 13,
  parameter int RD_LAT  = 1,
  parameter int ACC_W   = 32
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iStart,
  input  logic               iMode,
  input  logic               iAbortEn,
  input  logic [ACC_W-1:0]   iThreshold,
  input  logic [COORD_W-1:0] iXstart,
  input  logic [COORD_W-1:0] iYstart,
  input  logic [PIX_W-1:0]   reading_sram,
  input  logic [PIX_W-1:0]   reading_search,
  output logic [COORD_W-1:0] oX_sram,
  output logic [COORD_W-1:0] oY_sram,
  output logic [COORD_W-1:0] oX_search,
  output logic [COORD_W-1:0] oY_search,
  output logic               oBusy,
  output logic               oDone,
  output logic               oAborted,
  output logic [ACC_W-1:0]   oScore
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(TPL_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(TPL_H - 1);
  localparam logic [COORD_W-1:0] C_ONE  = COORD_W'(1);
  localparam logic [PIX_W:0]     PIX_MAX = {1'b0, {PIX_W{1'b1}}};

  logic [1:0]         state_q, state_d;
  logic [COORD_W-1:0] cnt_x_q, cnt_x_d, cnt_y_q, cnt_y_d;
  logic [COORD_W-1:0] xbase_q, xbase_d, ybase_q, ybase_d;
  logic               mode_q, mode_d, abort_en_q, abort_en_d;
  logic [ACC_W-1:0]   thr_q, thr_d, acc_q, acc_d, score_q, score_d;
  logic               aborted_q, aborted_d;
  logic [RD_LAT-1:0]  vld_q, vld_d;
  logic [COORD_W-1:0] x_sram_q, x_sram_d, y_sram_q, y_sram_d;
  logic [COORD_W-1:0] x_srch_q, x_srch_d, y_srch_q, y_srch_d;

  logic [PIX_W:0] diff_w, mag_w, term_w;
  logic           abort_hit;
  logic           last_addr;

  // Difference taken one bit wider so the sign bit selects the magnitude without underflow.
  always_comb begin
    diff_w = {1'b0, reading_sram} - {1'b0, reading_search};
    mag_w  = diff_w[PIX_W] ? ({(PIX_W+1){1'b0}} - diff_w) : diff_w;
    term_w = mode_q ? mag_w : (PIX_MAX - mag_w);
  end

  assign abort_hit = mode_q && abort_en_q && (acc_q > thr_q);
  assign last_addr = (cnt_x_q == X_LAST) && (cnt_y_q == Y_LAST);

  always_comb begin
    state_d    = state_q;
    cnt_x_d    = cnt_x_q;
    cnt_y_d    = cnt_y_q;
    xbase_d    = xbase_q;
    ybase_d    = ybase_q;
    mode_d     = mode_q;
    abort_en_d = abort_en_q;
    thr_d      = thr_q;
    acc_d      = acc_q;
    score_d    = score_q;
    aborted_d  = aborted_q;
    x_sram_d   = x_sram_q;
    y_sram_d   = y_sram_q;
    x_srch_d   = x_srch_q;
    y_srch_d   = y_srch_q;
    vld_d      = RD_LAT'({vld_q, 1'b0});
    case (state_q)
      S_IDLE, S_DONE: begin
        if (iStart) begin
          xbase_d    = iXstart;
          ybase_d    = iYstart;
          mode_d     = iMode;
          abort_en_d = iAbortEn;
          thr_d      = iThreshold;
          acc_d      = '0;
          aborted_d  = 1'b0;
          cnt_x_d    = '0;
          cnt_y_d    = '0;
          state_d    = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        if (abort_hit) begin
          // In-flight samples are dropped by clearing the valid pipe.
          state_d   = S_DONE;
          score_d   = acc_q;
          aborted_d = 1'b1;
          vld_d     = '0;
        end else begin
          if (vld_q[RD_LAT-1]) begin
            acc_d = acc_q + ACC_W'(term_w);
          end
          if (state_q == S_ISSUE) begin
            x_srch_d = cnt_x_q;
            y_srch_d = cnt_y_q;
            x_sram_d = xbase_q + cnt_x_q;
            y_sram_d = ybase_q + cnt_y_q;
            vld_d    = RD_LAT'({vld_q, 1'b1});
            if (cnt_x_q == X_LAST) begin
              cnt_x_d = '0;
              cnt_y_d = cnt_y_q + C_ONE;
            end else begin
              cnt_x_d = cnt_x_q + C_ONE;
            end
            if (last_addr) begin
              state_d = S_DRAIN;
            end
          end else if (vld_q == '0) begin
            state_d = S_DONE;
            score_d = acc_q;
          end
        end
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= S_IDLE;
      cnt_x_q    <= '0;
      cnt_y_q    <= '0;
      xbase_q    <= '0;
      ybase_q    <= '0;
      mode_q     <= 1'b0;
      abort_en_q <= 1'b0;
      thr_q      <= '0;
      acc_q      <= '0;
      score_q    <= '0;
      aborted_q  <= 1'b0;
      vld_q      <= '0;
      x_sram_q   <= '0;
      y_sram_q   <= '0;
      x_srch_q   <= '0;
      y_srch_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_x_q    <= cnt_x_d;
      cnt_y_q    <= cnt_y_d;
      xbase_q    <= xbase_d;
      ybase_q    <= ybase_d;
      mode_q     <= mode_d;
      abort_en_q <= abort_en_d;
      thr_q      <= thr_d;
      acc_q      <= acc_d;
      score_q    <= score_d;
      aborted_q  <= aborted_d;
      vld_q      <= vld_d;
      x_sram_q   <= x_sram_d;
      y_sram_q   <= y_sram_d;
      x_srch_q   <= x_srch_d;
      y_srch_q   <= y_srch_d;
    end
  end

  assign oX_sram   = x_sram_q;
  assign oY_sram   = y_sram_q;
  assign oX_search = x_srch_q;
  assign oY_search = y_srch_q;
  assign oBusy     = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign oDone     = (state_q == S_DONE);
  assign oAborted  = aborted_q;
  assign oScore    = score_q;

endmodule

// File: doc/template_corr_scorer.md
TEMPLATE_CORR_SCORER -- requirements
Module: template_corr_scorer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- PIX_W, 10: pixel width.
- TPL_W, 32: template width in pixels (1..512).
- TPL_H, 32: template height in pixels (1..512).
- COORD_W, 13: coordinate width.
- RD_LAT, 1: pixel-source read latency in clocks (1..4).
- ACC_W, 32: accumulator and score width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- iCLK, in, 1: clock.
- iRST_N, in, 1: reset, asynchronous, active-low.
- iStart, in, 1: start request.
- iMode, in, 1: 0 = similarity, 1 = SAD.
- iAbortEn, in, 1: enable SAD early abort.
- iThreshold, in, ACC_W: abort threshold.
- iXstart, in, COORD_W: window X origin.
- iYstart, in, COORD_W: window Y origin.
- reading_sram, in, PIX_W: image pixel.
- reading_search, in, PIX_W: template pixel.
- oX_sram, out, COORD_W: image read X.
- oY_sram, out, COORD_W: image read Y.
- oX_search, out, COORD_W: template read X.
- oY_search, out, COORD_W: template read Y.
- oBusy, out, 1: scan in progress.
- oDone, out, 1: one-cycle completion pulse.
- oAborted, out, 1: last scan ended by abort.
- oScore, out, ACC_W: final score.
REQ-003 The block SHALL use one clock, iCLK; reset iRST_N is asynchronous and active-low.

Function
REQ-004 FSM states SHALL be IDLE, ISSUE, DRAIN, DONE; DONE lasts exactly one cycle, then returns to IDLE.
REQ-005 iStart SHALL be accepted only in IDLE or DONE; at acceptance edge S it latches iXstart, iYstart, iMode, iAbortEn, iThreshold, clears the accumulator and oAborted, and enters ISSUE.
REQ-006 iStart in ISSUE or DRAIN SHALL be ignored with no side effect.
REQ-007 ISSUE SHALL present one address pair per cycle, raster order (x fastest), first pair registered at edge S+1, last (TPL_W-1, TPL_H-1) at edge S+N, N = TPL_W*TPL_H.
REQ-008 oX_search/oY_search SHALL equal the template offset (x, y); oX_sram = Xbase+x, oY_sram = Ybase+y, both modulo 2^COORD_W (wrap, no clamp).
REQ-009 After the last address the FSM SHALL enter DRAIN; address outputs hold their last value in DRAIN, DONE and IDLE.
REQ-010 The pixel pair for an address registered at edge t SHALL be sampled at edge t+RD_LAT via a RD_LAT-deep valid shift register.
REQ-011 Per-sample term SHALL be |sram-search| computed at PIX_W+1 bits without underflow: mode 0 adds (2^PIX_W-1)-|d|, mode 1 adds |d|.
REQ-012 The accumulator SHALL wrap modulo 2^ACC_W; with defaults no wrap occurs.
REQ-013 The final sample SHALL be accumulated at edge S+N+RD_LAT; oScore, DONE state and oDone=1 SHALL be registered at edge S+N+RD_LAT+1.
REQ-014 Early abort: in mode 1 with abort latched, if accumulator > threshold at any edge in ISSUE/DRAIN, the next edge SHALL enter DONE with oScore = accumulator and oAborted = 1; in-flight samples are discarded.
REQ-015 oBusy SHALL be 1 in ISSUE and DRAIN only.
REQ-016 oScore and oAborted SHALL hold until the next accepted iStart.
REQ-017 Mode 0 SHALL ignore iAbortEn.

Reset
REQ-018 iRST_N low SHALL immediately force IDLE; all outputs 0; counters, accumulator and valid pipe cleared, including mid-scan.
REQ-019 The first iStart after reset release SHALL start a clean scan with no residue from the aborted one.

Verification (TPL_W=TPL_H=4, PIX_W=10, RD_LAT=2, N=16)
REQ-020 Identical pixels, mode 0, start at edge S -> oDone at S+19, oScore=16368, oAborted=0.
REQ-021 Mode 1, sram=5, search=0 -> oScore=80; swap to sram=0, search=5 -> oScore=80.
REQ-022 iXstart=8190, iYstart=0 -> oX_sram row sequence 8190, 8191, 0, 1; oX_search 0..3.
REQ-023 Mode 1, |d|=10 every pixel, iAbortEn=1, iThreshold=20 -> oAborted=1, oScore=30, oDone before S+19.
REQ-024 iRST_N low for 1 cycle during ISSUE -> all outputs 0 at once; new start gives correct REQ-020 result.
REQ-025 iStart pulsed during ISSUE -> ignored, score unchanged; iStart in the DONE cycle -> accepted, oBusy=1 next edge.
